// File: rtl/my_program_counter_16.sv
// Program counter with conditional jump, stall and self-jump halt detection.
// Ports:
//   clk     - clock; all state updates on the rising edge
//   reset   - synchronous active-high reset (pc=0, state RUN)
//   stall   - hold all state this cycle
//   j       - jump enables {negative, zero, positive}
//   zr, ng  - ALU flags (result zero / result negative)
//   target  - jump destination address
//   pc      - current instruction address (registered)
//   halted  - registered; set once a taken jump targets its own address
//   taken   - combinational; jump condition true while running

// 16-bit +1 incrementer; wraps silently from 16'hFFFF to 16'h0000.
module my_incrementer_16 (
  input  logic [15:0] in,
  output logic [15:0] out
);

  localparam int unsigned W = 16;

  // Ripple carry chain: bit i toggles when all lower bits are one.
  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign out[i]     = in[i] ^ carry[i];
    assign carry[i+1] = in[i] & carry[i];
  end

endmodule

module my_program_counter_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  j,
  input  logic        zr,
  input  logic        ng,
  input  logic [15:0] target,
  output logic [15:0] pc,
  output logic        halted,
  output logic        taken
);

  localparam int unsigned AW = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state;
  logic          cond;
  logic [AW-1:0] pc_inc;

  // Jump condition; zr and ng both set is evaluated as-is.
  assign cond  = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  assign taken = (state == RUN) & cond;

  my_incrementer_16 u_inc (
    .in  (pc),
    .out (pc_inc)
  );

  // State, pc and halted update together; priority reset > stall > jump > increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc     <= AW'(0);
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (cond) begin
              // A taken jump onto itself can never make progress: stop here.
              if (target == pc) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= target;
              end
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HALT: begin
          // Only reset leaves HALT.
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_program_counter_16.sv
// Directed self-checking bench for my_program_counter_16.
module tb_my_program_counter_16;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  j;
  logic        zr;
  logic        ng;
  logic [15:0] target;
  logic [15:0] pc;
  logic        halted;
  logic        taken;

  int passed;
  int total;

  my_program_counter_16 dut (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .j      (j),
    .zr     (zr),
    .ng     (ng),
    .target (target),
    .pc     (pc),
    .halted (halted),
    .taken  (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move pc to a new address through a taken jump (target differs from pc).
  task automatic go_to(input logic [15:0] addr);
    j = 3'b111; zr = 1'b0; ng = 1'b0; stall = 1'b0; target = addr;
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1; stall = 1'b0; j = 3'b000; zr = 1'b0; ng = 1'b0; target = 16'h0000;
    step();
    reset = 1'b0;
    check("reset_pc", pc, 16'h0000);
    check("reset_halted", 16'(halted), 16'h0000);

    // Sequential increment 0,1,2,3
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("inc_pc_%0d", i), pc, 16'(i));
      check($sformatf("inc_halted_%0d", i), 16'(halted), 16'h0000);
    end
    step();
    step();
    check("at_pc5", pc, 16'h0005);

    // Combinational condition tables over all flag combinations
    for (int f = 0; f < 4; f++) begin
      zr = f[0]; ng = f[1];
      j = 3'b000; #1;
      check($sformatf("cond_j000_f%0d", f), 16'(taken), 16'h0000);
      j = 3'b111; #1;
      check($sformatf("cond_j111_f%0d", f), 16'(taken), 16'h0001);
    end
    j = 3'b001; zr = 1'b1; ng = 1'b1; #1;
    check("cond_j001_zr_ng", 16'(taken), 16'h0000);
    j = 3'b100; #1;
    check("cond_j100_zr_ng", 16'(taken), 16'h0001);

    // Conditional jumps from pc=5 to 0x0100
    j = 3'b001; zr = 1'b0; ng = 1'b0; target = 16'h0100; #1;
    check("j001_pos_taken", 16'(taken), 16'h0001);
    step();
    check("j001_pos_pc", pc, 16'h0100);
    check("j001_pos_halted", 16'(halted), 16'h0000);
    go_to(16'h0005);

    j = 3'b001; zr = 1'b1; ng = 1'b0; target = 16'h0100; #1;
    check("j001_zero_taken", 16'(taken), 16'h0000);
    step();
    check("j001_zero_pc", pc, 16'h0006);
    go_to(16'h0005);

    j = 3'b100; zr = 1'b0; ng = 1'b1; target = 16'h0100; #1;
    check("j100_neg_taken", 16'(taken), 16'h0001);
    step();
    check("j100_neg_pc", pc, 16'h0100);
    go_to(16'h0005);

    j = 3'b010; zr = 1'b1; ng = 1'b0; target = 16'h0100; #1;
    check("j010_zero_taken", 16'(taken), 16'h0001);
    step();
    check("j010_zero_pc", pc, 16'h0100);
    go_to(16'h0005);

    j = 3'b110; zr = 1'b0; ng = 1'b0; target = 16'h0100; #1;
    check("j110_pos_taken", 16'(taken), 16'h0000);
    step();
    check("j110_pos_pc", pc, 16'h0006);

    // Wrap from 0xFFFF
    go_to(16'hFFFF);
    check("load_ffff", pc, 16'hFFFF);
    j = 3'b000;
    step();
    check("wrap_pc", pc, 16'h0000);
    check("wrap_halted", 16'(halted), 16'h0000);

    // Stall holds pc even with a taken jump pending
    stall = 1'b1; j = 3'b111; target = 16'h0042;
    step();
    check("stall1_pc", pc, 16'h0000);
    step();
    check("stall2_pc", pc, 16'h0000);
    stall = 1'b0;

    // Self-jump under stall must not halt; releasing stall halts
    go_to(16'h0010);
    check("at_pc10", pc, 16'h0010);
    stall = 1'b1; j = 3'b111; target = 16'h0010;
    step();
    check("stall_selfjump_halted", 16'(halted), 16'h0000);
    check("stall_selfjump_pc", pc, 16'h0010);
    stall = 1'b0;
    step();
    check("halt_halted", 16'(halted), 16'h0001);
    check("halt_pc", pc, 16'h0010);

    // HALT ignores everything except reset
    target = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      stall = i[0];
      #1;
      check($sformatf("halt_taken_%0d", i), 16'(taken), 16'h0000);
      step();
      check($sformatf("halt_hold_pc_%0d", i), pc, 16'h0010);
      check($sformatf("halt_hold_flag_%0d", i), 16'(halted), 16'h0001);
    end
    stall = 1'b0;

    // Reset leaves HALT
    reset = 1'b1;
    step();
    check("rst_halt_pc", pc, 16'h0000);
    check("rst_halt_halted", 16'(halted), 16'h0000);
    reset = 1'b0; j = 3'b000;
    step();
    check("rst_halt_resume", pc, 16'h0001);

    // Reset discards a simultaneous taken jump
    j = 3'b111; target = 16'h0300; reset = 1'b1;
    step();
    check("rst_jump_pc", pc, 16'h0000);
    check("rst_jump_halted", 16'(halted), 16'h0000);
    reset = 1'b0; j = 3'b000;
    step();
    check("rst_jump_resume1", pc, 16'h0001);
    step();
    check("rst_jump_resume2", pc, 16'h0002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/my_program_counter_16.md
MY_PROGRAM_COUNTER_16 -- requirements
Module: my_program_counter_16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 stall  input  1  when 1, the block SHALL hold its state this cycle.
REQ-005 j  input  3  jump condition bits: j[2]=jump-if-negative, j[1]=jump-if-zero, j[0]=jump-if-positive.
REQ-006 zr  input  1  ALU flag: the result equals zero.
REQ-007 ng  input  1  ALU flag: the result is negative.
REQ-008 target  input  16  jump destination address.
REQ-009 pc  output  16  current instruction address, registered.
REQ-010 halted  output  1  registered; 1 once the program has reached a self-jump halt.
REQ-011 taken  output  1  combinational; jump condition currently true (see REQ-013).

Function
REQ-012 The block SHALL hold state in two states: RUN and HALT. halted SHALL be 1 exactly when the state is HALT.
REQ-013 The jump condition SHALL be cond = (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr). The taken output SHALL equal cond whenever the state is RUN, and SHALL be 0 in HALT.
REQ-014 With j=3'b000, cond SHALL be 0.
REQ-015 With j=3'b111, cond SHALL be 1 for every flag combination.
REQ-016 The zr=1, ng=1 input combination SHALL be evaluated literally by the formula, with no error checking.
REQ-017 In RUN, the next-state rules SHALL apply in this priority order: reset, then stall, then taken, then increment.
REQ-018 In RUN with stall=0 and taken=1, the next pc SHALL be target.
REQ-019 In RUN with stall=0 and taken=0, the next pc SHALL be pc+1.
REQ-020 The +1 path SHALL use one instance of the existing 16-bit incrementer block (my_incrementer_16).
REQ-021 Increment SHALL wrap from 16'hFFFF to 16'h0000 with no flag, and the block SHALL stay in RUN.
REQ-022 Halt detection: in RUN with stall=0, taken=1 and target==pc, the pc SHALL stay unchanged and the state SHALL go to HALT on that edge.
REQ-023 In HALT, pc SHALL hold regardless of stall, j, zr, ng and target, and only reset SHALL leave HALT.
REQ-024 A stalled cycle (stall=1) SHALL NOT trigger halt detection, even when taken=1 and target==pc.
REQ-025 A taken jump to any address other than pc SHALL load target and SHALL NOT set halted.
REQ-026 Update latency SHALL be exactly one cycle: a decision made in cycle N SHALL be visible on pc and halted in cycle N+1.
REQ-027 The block SHALL contain no combinational path from any input to pc or halted.

Reset
REQ-028 When reset=1 at a rising edge, pc SHALL become 16'h0000 and the state SHALL become RUN (halted=0).
REQ-029 Reset SHALL override stall, taken and HALT in the same cycle.
REQ-030 Reset asserted mid-sequence SHALL discard any pending jump: the next pc SHALL be 0, not target.
REQ-031 Outputs before the first reset are undefined. The bench SHALL apply reset before checking any output.

Verification
REQ-032 Reset, then 3 cycles with j=000, stall=0 -> pc sequence 0,1,2,3 and halted=0 throughout.
REQ-033 Conditional jumps from pc=5, target=16'h0100:
- j=001, zr=0, ng=0 -> pc=16'h0100 next cycle.
- j=001, zr=1 -> pc=6.
- j=100, ng=1 -> taken.
- j=010, zr=1 -> taken.
- j=110, zr=0, ng=0 -> not taken.
REQ-034 Wrap and stall:
- Load target=16'hFFFF via j=111, then j=000 -> pc=16'h0000 and halted=0.
- stall=1 for 2 cycles -> pc held, even with j=111 and target=16'h0042.
REQ-035 Halt: at pc=16'h0010, set j=111 and target=16'h0010 -> halted=1 next cycle and pc=16'h0010. Then j=111, target=16'h0020 for 3 cycles -> pc stays 16'h0010, halted stays 1, taken=0.
REQ-036 Same inputs as the halt scenario but with stall=1 -> halted stays 0. Releasing stall -> halted=1 one cycle later.
REQ-037 Reset while halted, and reset asserted in the same cycle as a taken jump (target=16'h0300) -> pc=0 and halted=0 next cycle. Normal increment resumes once reset is deasserted.
